// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - multi-cycle RV32M divide/remainder sequencer beside the ex stage
module ex_div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CALC  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d;     // original dividend, kept for sign fix-up
  logic [XLEN-1:0] dvs_q, dvs_d;     // original divisor
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] quo_q, quo_d;     // holds |dividend| while shifting, quotient at the end
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dmag_q, dmag_d;   // |divisor| used by the restoring steps
  logic [CW-1:0]   cnt_q, cnt_d;

  // Sign information of the latched operands; op bit 0 clear means a signed op
  logic            is_signed;
  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN:0]   rem_shift;
  logic            rem_ge;

  assign is_signed = ~op_q[0];
  assign dvd_neg   = is_signed & dvd_q[XLEN-1];
  assign dvs_neg   = is_signed & dvs_q[XLEN-1];
  // One extra bit so the shifted partial remainder never overflows for large unsigned divisors
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dmag_q});

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rd_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rd_q    <= rd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dmag_q  <= dmag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath updates and the pipeline hold request
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rd_d    = rd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          stall_o = 1'b1;
          op_d    = op_i;
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          rd_d    = rd_addr_i;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_q;
          state_d = S_DONE;
        end else if (is_signed && (dvd_q == INT_MIN) && (dvs_q == '1)) begin
          quo_d   = INT_MIN;
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          quo_d   = dvd_neg ? (~dvd_q + 1'b1) : dvd_q;
          dmag_d  = dvs_neg ? (~dvs_q + 1'b1) : dvs_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (rem_ge) begin
            rem_d = rem_shift[XLEN-1:0] - dmag_q;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (dvd_neg ^ dvs_neg) begin
            quo_d = ~quo_q + 1'b1;
          end
          if (dvd_neg) begin
            rem_d = ~rem_q + 1'b1;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // start_i still high here belongs to the instruction now leaving ex
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Write port is only driven during the single DONE cycle, and a flush there cancels it
  assign busy_o    = (state_q != S_IDLE);
  assign rd_wen_o  = (state_q == S_DONE) && !flush_i;
  assign rd_data_o = rd_wen_o ? (op_q[1] ? rem_q : quo_q) : '0;
  assign rd_addr_o = rd_wen_o ? rd_q : '0;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - randomized self-checking bench for ex_div_ctrl
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        busy_o;
  logic        stall_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;

  int checks = 0;
  int failures = 0;

  ex_div_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (a),
    .divisor_i  (b),
    .rd_addr_i  (rd),
    .flush_i    (flush),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .rd_data_o  (rd_data_o),
    .rd_addr_o  (rd_addr_o),
    .rd_wen_o   (rd_wen_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics computed directly with language arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (o[0]) return o[1] ? (x % y) : (x / y);
    return o[1] ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  function automatic bit ref_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Issue one divide in the current cycle (T) and follow it to the write cycle and the IDLE after it.
  // With hold set, start_i stays high through DONE and is still high on return (chained issue).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input bit hold);
    logic [31:0] exp;
    int lat;
    int first;
    int stall_n;
    exp = ref_result(o, x, y);
    lat = ref_special(o, x, y) ? 2 : 35;
    op = o; a = x; b = y; rd = r; start = 1'b1;
    #1;
    check({tag, "_stall_T"}, {31'd0, stall_o}, 32'd1);
    first = 0;
    stall_n = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      #1;
      if (rd_wen_o) begin
        first = k;
        check({tag, "_data"}, rd_data_o, exp);
        check({tag, "_addr"}, {27'd0, rd_addr_o}, {27'd0, r});
        check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
      end else if (stall_o) begin
        stall_n++;
      end
    end
    check({tag, "_latency"}, first, lat);
    check({tag, "_stall_cycles"}, stall_n, lat - 1);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    #1;
    check({tag, "_busy_idle"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_wen_idle"}, {31'd0, rd_wen_o}, 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    int          kind;
    bit          seen;

    // Reset values
    #2;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_wen", {31'd0, rd_wen_o}, 32'd0);
    check("rst_data", rd_data_o, 32'd0);
    check("rst_addr", {27'd0, rd_addr_o}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd6, 1'b0);
    run_op("div_m7_2", 2'b00, -32'sd7, 32'd2, 5'd7, 1'b0);
    run_op("rem_m7_2", 2'b10, -32'sd7, 32'd2, 5'd8, 1'b0);
    run_op("divu_by0", 2'b01, 32'd9, 32'd0, 5'd9, 1'b0);
    run_op("rem_by0", 2'b10, 32'd5, 32'd0, 5'd10, 1'b0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    run_op("divu_ovfpat", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op("div_rd0", 2'b00, 32'd50, -32'sd5, 5'd0, 1'b0);

    // Back-to-back with start held across DONE
    run_op("b2b_a", 2'b01, 32'hFFFF_FFFF, 32'd3, 5'd14, 1'b1);
    run_op("b2b_b", 2'b10, -32'sd100, -32'sd7, 5'd15, 1'b1);
    run_op("b2b_c", 2'b00, 32'd1, 32'd0, 5'd16, 1'b1);
    start = 1'b0;

    // Flush mid-calculation, then a fresh start completes normally
    op = 2'b01; a = 32'd1000; b = 32'd3; rd = 5'd17; start = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      flush = (k == 10);
      #1;
      if (rd_wen_o) seen = 1'b1;
      if (k == 11) check("flush_busy", {31'd0, busy_o}, 32'd0);
    end
    check("flush_no_wen", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    run_op("after_flush", 2'b01, 32'd1000, 32'd3, 5'd18, 1'b0);

    // Flush in the DONE cycle suppresses the write
    op = 2'b11; a = 32'd77; b = 32'd10; rd = 5'd19; start = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (rd_wen_o) begin
        seen = 1'b1;
        flush = 1'b1;
        #1;
        check("flushdone_wen", {31'd0, rd_wen_o}, 32'd0);
        check("flushdone_data", rd_data_o, 32'd0);
      end
    end
    check("flushdone_reached", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flushdone_busy", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset mid-operation
    op = 2'b00; a = 32'd12345; b = 32'd11; rd = 5'd20; start = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (rd_wen_o) seen = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    check("arst_wen", {31'd0, rd_wen_o}, 32'd0);
    check("arst_data", rd_data_o, 32'd0);
    check("arst_addr", {27'd0, rd_addr_o}, 32'd0);
    check("arst_no_wen", {31'd0, seen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 5);
      rx = $urandom;
      ry = $urandom;
      if (kind == 0) ry = 32'd0;
      else if (kind == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (kind == 2) begin
        rx = 32'($urandom_range(0, 200)) - 32'd100;
        ry = 32'($urandom_range(0, 20)) - 32'd10;
      end else if (kind == 3) ry = ry >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), ro, rx, ry, 5'($urandom), 1'($urandom));
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
